// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: arbitrates hazards into per-segment stall/refresh and PC hold.
// Latency: stall/refresh outputs are combinational from inputs and current state (same-edge effect).
// Backpressure: data wait > mult/div > load-use > fetch wait; exception flush overrides all but a pending data wait.
// Optional feature macro: PIPE_MD_STALL_EN builds the multi-cycle mult/div occupancy sequencer.
module pipe_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       if_wait,
    input  logic       id_rs_ren,
    input  logic       id_rt_ren,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_load,
    input  logic       ex_cp0ren,
    input  logic       ex_regwen,
    input  logic [4:0] ex_wreg,
    input  logic       ex_mult,
    input  logic       ex_div,
    input  logic       mem_data_req,
    input  logic       data_ok,
    input  logic       mem_exc,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       ex_mem_stall,
    output logic       mem_wb_stall,
    output logic       if_id_refresh,
    output logic       id_ex_refresh,
    output logic       ex_mem_refresh,
    output logic       mem_wb_refresh,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic {
        DIDLE = 1'b0,
        DWAIT = 1'b1
    } dstate_t;

    dstate_t dstate;

    logic lu;        // load-use hazard between EX producer and ID consumer
    logic dw;        // MEM is waiting on the data SRAM
    logic exc_take;  // exception/eret flush actually honoured this cycle
    logic ms;        // EX is occupied by a multi-cycle mult/div

    // A GPR produced by a load or mfc0 in EX is not available to ID until next cycle.
    assign lu = (ex_load | ex_cp0ren) & ex_regwen & (ex_wreg != 5'd0) &
                ((id_rs_ren & (id_rs == ex_wreg)) | (id_rt_ren & (id_rt == ex_wreg)));

    // data_ok releases the wait in the very cycle it arrives.
    assign dw = (mem_data_req | (dstate == DWAIT)) & ~data_ok;

    // An access already in flight cannot be abandoned, so the flush waits it out.
    assign exc_take = mem_exc & (dstate != DWAIT);

    // Track an outstanding data access until its data_ok returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dstate <= DIDLE;
        end else begin
            case (dstate)
                DIDLE:   if (mem_data_req & ~data_ok) dstate <= DWAIT;
                DWAIT:   if (data_ok) dstate <= DIDLE;
                default: dstate <= DIDLE;
            endcase
        end
    end

`ifdef PIPE_MD_STALL_EN
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } mdstate_t;

    // Counter is 6 bits wide, so occupancies up to 64 cycles are representable.
    localparam logic [5:0] MUL_INIT = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_INIT = 6'(DIV_CYCLES - 1);

    mdstate_t   md_state;
    logic [5:0] cnt;

    // Sequence mult/div occupancy of EX; a flush abandons the operation outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_state <= MD_IDLE;
            cnt      <= 6'd0;
        end else if (exc_take) begin
            md_state <= MD_IDLE;
            cnt      <= 6'd0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (ex_mult | ex_div) begin
                        md_state <= MD_BUSY;
                        // Divide takes precedence when both decode bits are set.
                        cnt      <= ex_div ? DIV_INIT : MUL_INIT;
                    end
                end
                MD_BUSY: begin
                    // The unit keeps computing even while MEM waits on data.
                    if (cnt == 6'd0) begin
                        md_state <= MD_DONE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                MD_DONE: begin
                    // Result is only consumed once EX can actually advance.
                    if (~dw) md_state <= MD_IDLE;
                end
                default: begin
                    md_state <= MD_IDLE;
                    cnt      <= 6'd0;
                end
            endcase
        end
    end

    assign ms      = ((md_state == MD_IDLE) & (ex_mult | ex_div)) |
                     (md_state == MD_BUSY) |
                     ((md_state == MD_DONE) & dw);
    assign md_busy = (md_state != MD_IDLE);
    assign md_done = (md_state == MD_DONE) & ~dw & ~exc_take;
`else
    // Single-cycle HI/LO unit: EX is never held by mult/div.
    localparam int MD_PARAMS_UNUSED = MUL_CYCLES + DIV_CYCLES;
    logic md_inputs_unused;
    assign md_inputs_unused = ex_mult ^ ex_div;
    assign ms      = 1'b0;
    assign md_busy = 1'b0;
    assign md_done = 1'b0;
`endif

    // Resolve all stall sources into one stall/refresh pattern by priority.
    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        id_ex_stall    = 1'b0;
        ex_mem_stall   = 1'b0;
        mem_wb_stall   = 1'b0;
        if_id_refresh  = 1'b0;
        id_ex_refresh  = 1'b0;
        ex_mem_refresh = 1'b0;
        mem_wb_refresh = 1'b0;
        if (reset | exc_take) begin
            // Flush every segment; nothing is held.
            if_id_refresh  = 1'b1;
            id_ex_refresh  = 1'b1;
            ex_mem_refresh = 1'b1;
            mem_wb_refresh = 1'b1;
        end else if (dw) begin
            // Freeze everything up to MEM; WB gets a bubble.
            pc_stall       = 1'b1;
            if_id_stall    = 1'b1;
            id_ex_stall    = 1'b1;
            ex_mem_stall   = 1'b1;
            mem_wb_refresh = 1'b1;
        end else if (ms) begin
            // Hold EX and everything upstream; MEM gets a bubble.
            pc_stall       = 1'b1;
            if_id_stall    = 1'b1;
            id_ex_stall    = 1'b1;
            ex_mem_refresh = 1'b1;
        end else if (lu) begin
            // Hold the consumer in ID; EX gets a bubble.
            pc_stall       = 1'b1;
            if_id_stall    = 1'b1;
            id_ex_refresh  = 1'b1;
        end else if (if_wait) begin
            // Fetch not back yet; ID gets a bubble.
            pc_stall       = 1'b1;
            if_id_refresh  = 1'b1;
        end
    end

    // A segment is never asked to both hold and take a bubble.
    a_if_id_excl: assert property (@(posedge clk) disable iff (reset)
        !(if_id_stall && if_id_refresh));
    a_id_ex_excl: assert property (@(posedge clk) disable iff (reset)
        !(id_ex_stall && id_ex_refresh));
    a_ex_mem_excl: assert property (@(posedge clk) disable iff (reset)
        !(ex_mem_stall && ex_mem_refresh));
    a_mem_wb_excl: assert property (@(posedge clk) disable iff (reset)
        !(mem_wb_stall && mem_wb_refresh));
    // A completion pulse is only produced while the unit is occupied.
    a_done_busy: assert property (@(posedge clk) disable iff (reset)
        md_done |-> md_busy);

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int MUL_N = 2;
    localparam int DIV_N = 33;

    // Output vector order: 5 stalls (pc,if_id,id_ex,ex_mem,mem_wb), 4 refreshes, md_busy, md_done.
    localparam logic [10:0] O_NONE = 11'b00000_0000_00;
    localparam logic [10:0] O_RST  = 11'b00000_1111_00;
    localparam logic [10:0] O_EXC  = 11'b00000_1111_00;
    localparam logic [10:0] O_DW   = 11'b11110_0001_00;
    localparam logic [10:0] O_MS   = 11'b11100_0010_00;
    localparam logic [10:0] O_LU   = 11'b11000_0100_00;
    localparam logic [10:0] O_IFW  = 11'b10000_1000_00;
    localparam logic [10:0] O_BUSY = 11'b00000_0000_10;
    localparam logic [10:0] O_DONE = 11'b00000_0000_11;

    typedef struct packed {
        logic       if_wait;
        logic       id_rs_ren;
        logic       id_rt_ren;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       ex_load;
        logic       ex_cp0ren;
        logic       ex_regwen;
        logic [4:0] ex_wreg;
        logic       ex_mult;
        logic       ex_div;
        logic       mem_data_req;
        logic       data_ok;
        logic       mem_exc;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [10:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic if_wait, id_rs_ren, id_rt_ren, ex_load, ex_cp0ren, ex_regwen;
    logic ex_mult, ex_div, mem_data_req, data_ok, mem_exc;
    logic [4:0] id_rs, id_rt, ex_wreg;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh;
    logic md_busy, md_done;
    logic [10:0] outs;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    bit m_out;        // a data access is outstanding
`ifdef PIPE_MD_STALL_EN
    bit m_active;     // a mult/div has been issued and not yet retired
    int m_issue;      // cycle number of the issue
    int m_len;        // occupancy N of that operation
`endif
    int m_cyc;

    always #5 clk = ~clk;

    assign outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                   if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh,
                   md_busy, md_done};

    pipe_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .if_wait(if_wait),
        .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren), .id_rs(id_rs), .id_rt(id_rt),
        .ex_load(ex_load), .ex_cp0ren(ex_cp0ren), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg),
        .ex_mult(ex_mult), .ex_div(ex_div), .mem_data_req(mem_data_req), .data_ok(data_ok),
        .mem_exc(mem_exc), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
        .if_id_refresh(if_id_refresh), .id_ex_refresh(id_ex_refresh),
        .ex_mem_refresh(ex_mem_refresh), .mem_wb_refresh(mem_wb_refresh),
        .md_busy(md_busy), .md_done(md_done)
    );

    task automatic drive(input in_t v);
        if_wait      = v.if_wait;
        id_rs_ren    = v.id_rs_ren;
        id_rt_ren    = v.id_rt_ren;
        id_rs        = v.id_rs;
        id_rt        = v.id_rt;
        ex_load      = v.ex_load;
        ex_cp0ren    = v.ex_cp0ren;
        ex_regwen    = v.ex_regwen;
        ex_wreg      = v.ex_wreg;
        ex_mult      = v.ex_mult;
        ex_div       = v.ex_div;
        mem_data_req = v.mem_data_req;
        data_ok      = v.data_ok;
        mem_exc      = v.mem_exc;
    endtask

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, got, exp);
    endtask

    // One cycle: drive just after the edge, compare at the falling edge.
    task automatic cyc_check(input string name, input in_t v, input logic [10:0] exp);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check(name, outs, exp);
    endtask

    // Expected outputs from the priority rules and the model's abstract state.
    function automatic logic [10:0] model_eval(input in_t r);
        logic waiting, exc, lu, md_st, busy, done;
        logic [8:0] sr;
        waiting = (r.mem_data_req || m_out) && !r.data_ok;
        exc     = r.mem_exc && !m_out;
        lu      = (r.ex_load || r.ex_cp0ren) && r.ex_regwen && (r.ex_wreg != 5'd0) &&
                  ((r.id_rs_ren && r.id_rs == r.ex_wreg) || (r.id_rt_ren && r.id_rt == r.ex_wreg));
        md_st = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
`ifdef PIPE_MD_STALL_EN
        if (m_active) begin
            busy  = 1'b1;
            md_st = ((m_cyc - m_issue) <= m_len) || waiting;
            done  = ((m_cyc - m_issue) > m_len) && !waiting && !exc;
        end else begin
            md_st = r.ex_mult || r.ex_div;
        end
`endif
        if (exc)             sr = 9'b00000_1111;
        else if (waiting)    sr = 9'b11110_0001;
        else if (md_st)      sr = 9'b11100_0010;
        else if (lu)         sr = 9'b11000_0100;
        else if (r.if_wait)  sr = 9'b10000_1000;
        else                 sr = 9'b00000_0000;
        return {sr, busy, done};
    endfunction

    task automatic model_step(input in_t r);
        logic waiting, exc;
        waiting = (r.mem_data_req || m_out) && !r.data_ok;
        exc     = r.mem_exc && !m_out;
`ifdef PIPE_MD_STALL_EN
        if (exc) m_active = 1'b0;
        else if (!m_active && (r.ex_mult || r.ex_div)) begin
            m_active = 1'b1;
            m_issue  = m_cyc;
            m_len    = r.ex_div ? DIV_N : MUL_N;
        end else if (m_active && (m_cyc - m_issue) > m_len && !waiting) m_active = 1'b0;
`else
        if (exc) m_cyc = m_cyc;
`endif
        if (!m_out && r.mem_data_req && !r.data_ok) m_out = 1'b1;
        else if (m_out && r.data_ok) m_out = 1'b0;
        m_cyc++;
    endtask

    vec_t vecs[$];

    task automatic add(input string name, input in_t v, input logic [10:0] exp);
        vec_t e;
        e.name = name;
        e.in   = v;
        e.exp  = exp;
        vecs.push_back(e);
    endtask

    initial begin
        in_t b, lu5, z, r;
        logic [10:0] exp;
        z = '0;

        // Combinational vectors, applied from the idle state (none cause a state change).
        lu5 = '0; lu5.ex_load = 1; lu5.ex_regwen = 1; lu5.ex_wreg = 5; lu5.id_rs_ren = 1; lu5.id_rs = 5;
        add("lu_rs", lu5, O_LU);
        b = lu5; b.ex_wreg = 0; b.id_rs = 0;           add("lu_r0", b, O_NONE);
        b = '0; b.ex_cp0ren = 1; b.ex_regwen = 1; b.ex_wreg = 7; b.id_rt_ren = 1; b.id_rt = 7;
        add("lu_rt_cp0", b, O_LU);
        b = lu5; b.id_rs_ren = 0;                      add("lu_noren", b, O_NONE);
        b = lu5; b.ex_regwen = 0;                      add("lu_noregwen", b, O_NONE);
        b = lu5; b.id_rs = 6;                          add("lu_mismatch", b, O_NONE);
        b = lu5; b.ex_load = 0;                        add("lu_notload", b, O_NONE);
        b = '0; b.if_wait = 1;                         add("ifwait", b, O_IFW);
        b = lu5; b.if_wait = 1;                        add("lu_over_ifwait", b, O_LU);
        b = '0; b.mem_data_req = 1; b.data_ok = 1;     add("req_ok_same", b, O_NONE);
        b = lu5; b.mem_data_req = 1; b.data_ok = 1;    add("req_ok_lu", b, O_LU);
        b = lu5; b.if_wait = 1; b.mem_exc = 1;         add("exc_over_all", b, O_EXC);
        b = '0; b.data_ok = 1;                         add("stray_ok", b, O_NONE);

        reset = 1'b1;
        drive(z);
        @(negedge clk);
        check("reset_state", outs, O_RST);
        b = lu5; b.if_wait = 1; drive(b);
        #1;
        check("reset_ignores_inputs", outs, O_RST);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(z);

        foreach (vecs[i]) cyc_check(vecs[i].name, vecs[i].in, vecs[i].exp);

        // Load-use lasts exactly the one cycle the load is in EX.
        cyc_check("lu_once", lu5, O_LU);
        b = '0; b.id_rs_ren = 1; b.id_rs = 5;
        cyc_check("lu_gone", b, O_NONE);

        // Data wait: request at cycle 0, data_ok at cycle 4; flush is ignored while waiting.
        b = '0; b.mem_data_req = 1;
        cyc_check("dw_c0", b, O_DW);
        cyc_check("dw_c1", z, O_DW);
        b = '0; b.mem_exc = 1;
        cyc_check("dw_exc_ignored", b, O_DW);
        cyc_check("dw_c3", z, O_DW);
        b = '0; b.data_ok = 1;
        cyc_check("dw_release", b, O_NONE);
        cyc_check("dw_after", z, O_NONE);

`ifdef PIPE_MD_STALL_EN
        // Mult: stalled cycles 0..2, md_done in cycle 3.
        b = '0; b.ex_mult = 1;
        cyc_check("mul_issue", b, O_MS);
        for (int k = 1; k <= MUL_N; k++) cyc_check("mul_busy", b, O_MS | O_BUSY);
        cyc_check("mul_done", b, O_DONE);
        cyc_check("mul_idle", z, O_NONE);

        // Div: stalled cycles 0..33, md_done in cycle 34.
        b = '0; b.ex_div = 1;
        cyc_check("div_issue", b, O_MS);
        for (int k = 1; k <= DIV_N; k++) cyc_check("div_busy", b, O_MS | O_BUSY);
        cyc_check("div_done", b, O_DONE);
        cyc_check("div_idle", z, O_NONE);

        // Flush while the divider counts (cnt==10 in cycle 23) abandons it silently.
        cyc_check("dexc_issue", b, O_MS);
        for (int k = 1; k <= 22; k++) cyc_check("dexc_busy", b, O_MS | O_BUSY);
        b.mem_exc = 1;
        cyc_check("dexc_flush", b, O_EXC | O_BUSY);
        cyc_check("dexc_after", z, O_NONE);
        cyc_check("dexc_after2", z, O_NONE);

        // DONE meets a two-cycle data wait: completion deferred until data_ok.
        b = '0; b.ex_mult = 1;
        cyc_check("mdw_issue", b, O_MS);
        for (int k = 1; k <= MUL_N; k++) cyc_check("mdw_busy", b, O_MS | O_BUSY);
        b.mem_data_req = 1;
        cyc_check("mdw_hold0", b, O_DW | O_BUSY);
        b.mem_data_req = 0;
        cyc_check("mdw_hold1", b, O_DW | O_BUSY);
        b.data_ok = 1;
        cyc_check("mdw_done", b, O_DONE);
        cyc_check("mdw_idle", z, O_NONE);

        // Reset in the middle of a divide drops md_busy at once.
        b = '0; b.ex_div = 1;
        cyc_check("rst_issue", b, O_MS);
        for (int k = 1; k <= 4; k++) cyc_check("rst_busy", b, O_MS | O_BUSY);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", outs, O_RST);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(z);
        @(negedge clk);
        check("rst_after", outs, O_NONE);
`else
        // Without the sequencer mult/div never hold the pipeline.
        b = '0; b.ex_mult = 1; b.ex_div = 1;
        cyc_check("md_off_0", b, O_NONE);
        cyc_check("md_off_1", b, O_NONE);
        b = lu5; b.ex_div = 1;
        cyc_check("md_off_lu", b, O_LU);
`endif

        // Randomized phase from a clean reset against the reference model.
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(z);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_out = 1'b0;
`ifdef PIPE_MD_STALL_EN
        m_active = 1'b0;
        m_issue  = 0;
        m_len    = 0;
`endif
        m_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) begin
                @(posedge clk);
                #1;
            end
            r = '0;
            r.if_wait      = ($urandom_range(0, 3) == 0);
            r.id_rs_ren    = 1'($urandom_range(0, 1));
            r.id_rt_ren    = 1'($urandom_range(0, 1));
            r.id_rs        = 5'($urandom_range(0, 3));
            r.id_rt        = 5'($urandom_range(0, 3));
            r.ex_load      = ($urandom_range(0, 2) == 0);
            r.ex_cp0ren    = ($urandom_range(0, 7) == 0);
            r.ex_regwen    = 1'($urandom_range(0, 1));
            r.ex_wreg      = 5'($urandom_range(0, 3));
            r.ex_mult      = ($urandom_range(0, 15) == 0);
            r.ex_div       = ($urandom_range(0, 39) == 0);
            r.mem_data_req = ($urandom_range(0, 4) == 0);
            r.data_ok      = ($urandom_range(0, 2) == 0);
            r.mem_exc      = !m_out && !r.mem_data_req && ($urandom_range(0, 29) == 0);
            drive(r);
            exp = model_eval(r);
            @(negedge clk);
            check("rand", outs, exp);
            model_step(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

- Central stall/flush controller for the five-stage pipeline.
- Drives the `stall` and `refresh` inputs of the `if_id`, `id_ex`, `ex_mem` and `mem_wb` segment registers, plus the PC hold.
- Arbitrates stall sources: load-use hazards, multi-cycle mult/div occupancy of EX, outstanding data-SRAM accesses, fetch wait, and exception/eret flush.
- Sequences mult/div occupancy with a cycle counter and tracks outstanding data accesses with a wait FSM.

## Interface
Parameters:
- `MUL_CYCLES`, default 2: cycles the multiplier occupies EX after issue (≥1).
- `DIV_CYCLES`, default 33: cycles the divider occupies EX after issue (≥1).

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `if_wait` in 1: IF instruction not yet returned.
- `id_rs_ren`, `id_rt_ren` in 1 each: ID reads GPR[rs] / GPR[rt].
- `id_rs`, `id_rt` in 5 each: ID source register numbers.
- `ex_load`, `ex_cp0ren`, `ex_regwen` in 1 each: EX instruction is a load / mfc0 / writes a GPR.
- `ex_wreg` in 5: EX destination register.
- `ex_mult`, `ex_div` in 1 each: EX holds a mult / div.
- `mem_data_req` in 1: MEM instruction issuing a data access.
- `data_ok` in 1: data access complete.
- `mem_exc` in 1: exception or eret taken in MEM.
- `pc_stall` out 1: hold the PC.
- `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall` out 1 each: hold the segment.
- `if_id_refresh`, `id_ex_refresh`, `ex_mem_refresh`, `mem_wb_refresh` out 1 each: load a bubble into the segment.
- `md_busy` out 1: mult/div FSM not IDLE.
- `md_done` out 1: one-cycle pulse when the result is valid and EX advances.

## Operation
- Load-use hazard, `lu`: `(ex_load|ex_cp0ren) & ex_regwen & ex_wreg!=0 & ((id_rs_ren & id_rs==ex_wreg) | (id_rt_ren & id_rt==ex_wreg))`.
- Data wait, `dw`: `(mem_data_req | dstate==DWAIT) & !data_ok`.
- Data FSM:
  - DIDLE→DWAIT when `mem_data_req & !data_ok`.
  - DWAIT→DIDLE on `data_ok`.
- Mult/div FSM has states IDLE, BUSY and DONE, with a 6-bit counter `cnt`.
  - IDLE & (`ex_mult`|`ex_div`) & !`mem_exc` → BUSY; `cnt` ← `MUL_CYCLES-1` or `DIV_CYCLES-1` (div wins if both are set).
  - BUSY: `cnt` decrements every cycle, independent of `dw`. At `cnt==0` → DONE.
  - DONE: if `!dw` → IDLE; otherwise hold DONE.
  - `md_done` = (state==DONE) & `!dw`.
- `ms` (md stall) = (IDLE & (`ex_mult`|`ex_div`)) | BUSY | (DONE & `dw`).
- Output priority, highest first; unlisted outputs are 0:
  1. `mem_exc` (ignored while dstate==DWAIT): all four refresh outputs = 1, all stall outputs = 0. Mult/div FSM → IDLE and `cnt` → 0, with no `md_done`.
  2. `dw`: `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` = 1; `mem_wb_refresh` = 1.
  3. `ms`: `pc_stall`, `if_id_stall`, `id_ex_stall` = 1; `ex_mem_refresh` = 1.
  4. `lu`: `pc_stall`, `if_id_stall` = 1; `id_ex_refresh` = 1.
  5. `if_wait`: `pc_stall` = 1; `if_id_refresh` = 1.
- A stage's stall and refresh outputs are never both 1.

## Timing
- Reset (asynchronous): dstate=DIDLE, mdstate=IDLE, `cnt`=0. While `reset`=1, all refresh outputs are 1 and all stall outputs, `md_busy` and `md_done` are 0.
- All stall and refresh outputs are combinational from the inputs and current state, so they take effect at the same posedge.
- `data_ok` releases the stall in the cycle it is asserted: zero-cycle turnaround.
- Mult/div issue at cycle 0: EX is stalled cycles 0..N, where N = `MUL_CYCLES` or `DIV_CYCLES`. `md_done` is asserted in cycle N+1, and EX advances at the end of that cycle.
- If `dw` coincides with DONE, both the `md_done` pulse and the EX advance are deferred until `dw` drops.
- `reset` mid-operation aborts both FSMs immediately.

## Configuration
- `PIPE_MD_STALL_EN` defined: mult/div FSM and counter built as described.
- Undefined: the FSM and counter are removed; `ms`, `md_busy` and `md_done` are tied to 0, and `ex_mult`/`ex_div` are ignored, for a single-cycle HI/LO unit.

## Test plan
- Load-use: `ex_load=1`, `ex_regwen=1`, `ex_wreg=5`, `id_rs_ren=1`, `id_rs=5` → `pc_stall`/`if_id_stall` = 1 and `id_ex_refresh`=1 for exactly 1 cycle. Repeat with `ex_wreg=0` → no stall.
- Mult with `MUL_CYCLES=2`: `ex_mult` held → `id_ex_stall`=1 for 3 cycles, then `md_done`=1 for 1 cycle. Div with `DIV_CYCLES=33` → 34 stall cycles, then `md_done`.
- Data wait: `mem_data_req=1` with `data_ok` arriving after 4 cycles → `ex_mem_stall` and `mem_wb_refresh` = 1 for cycles 0..3 and 0 in cycle 4. `mem_data_req` together with `data_ok` in the same cycle → no stall.
- Div in BUSY with `cnt`=10, then `mem_exc` → next cycle: IDLE, `md_busy`=0, no `md_done`; all refresh outputs = 1 in the `mem_exc` cycle.
- DONE coinciding with a 2-cycle data wait → mdstate stays DONE and `md_done`=0 for 2 cycles, then `md_done`=1. Assert `reset` mid-BUSY → `md_busy`=0 immediately.
